seq_wide_adder_ctrl: RTL and testbench

SEQ_WIDE_ADDER_CTRL -- requirements
Module: seq_wide_adder_ctrl

---
 rtl/seq_wide_adder_ctrl.sv | 105 ++++++++++
 tb/tb_seq_wide_adder_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_wide_adder_ctrl.sv
// Sequential wide adder: one 16-bit slice walks NUM_WORDS words LSW first,
// with a valid/ready handshake on both the operand and the result side.
module seq_wide_adder_ctrl #(
   parameter  int NUM_WORDS = 4,
   localparam int WIDTH     = 16 * NUM_WORDS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum0,
   output logic             out_c,
   output logic             out_v,
   output logic             busy
);

   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      DONE
   } state_t;

   state_t state, next_state;

   logic [NUM_WORDS-1:0][15:0] a_q, b_q, sum_q;
   logic [IDX_W-1:0]           idx;
   logic                       carry;
   logic [16:0]                slice;
   logic                       msb_cin;

   assign slice   = {1'b0, a_q[idx]} + {1'b0, b_q[idx]} + {16'b0, carry};
   // Carry into the top bit of the word, recovered from the slice's sum bit.
   assign msb_cin = a_q[idx][15] ^ b_q[idx][15] ^ slice[15];

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // NOTE: next_state gets its default before the case so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid)        next_state = ADD;
         ADD:     if (idx == LAST_IDX) next_state = DONE;
         DONE:    if (out_ready)       next_state = IDLE;
         default:                      next_state = IDLE;
      endcase
   end

   // NOTE: operand registers carry no reset; they are only read after a load
   // in IDLE, so their power-up contents never reach an output.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         a_q <= in_a;
         b_q <= in_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx   <= '0;
         carry <= 1'b0;
         sum_q <= '0;
         out_c <= 1'b0;
         out_v <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  idx   <= '0;
                  carry <= in_c;
               end
            end
            ADD: begin
               sum_q[idx] <= slice[15:0];
               carry      <= slice[16];
               idx        <= idx + IDX_W'(1);
               if (idx == LAST_IDX) begin
                  out_c <= slice[16];
                  out_v <= msb_cin ^ slice[16];
               end
            end
            default: ;
         endcase
      end
   end

   assign sum0      = sum_q;
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
// Directed self-checking bench for seq_wide_adder_ctrl with NUM_WORDS=4.
module tb_seq_wide_adder_ctrl;

   localparam int NW = 4;
   localparam int W  = 16 * NW;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_c;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum0;
   logic         out_c;
   logic         out_v;
   logic         busy;

   int n_cmp = 0;
   int n_err = 0;

   seq_wide_adder_ctrl #(.NUM_WORDS(NW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum0      (sum0),
      .out_c     (out_c),
      .out_v     (out_v),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for out_valid within a bounded budget and checks the latency.
   task automatic wait_done(input string tag, input int exp_lat);
      int cyc;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         step();
         cyc++;
      end
      check({tag, "_latency"}, W'(cyc), W'(exp_lat));
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W-1:0] exp_sum, input logic exp_c,
                         input logic exp_v, input bit do_release);
      in_a      = a;
      in_b      = b;
      in_c      = c;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      check({tag, "_in_ready"}, W'(in_ready), W'(1));
      step();
      in_valid = 1'b0;
      in_a     = ~a;
      in_b     = ~b;
      in_c     = ~c;
      check({tag, "_busy"}, W'(busy), W'(1));
      wait_done(tag, NW);
      check({tag, "_sum0"}, sum0, exp_sum);
      check({tag, "_out_c"}, W'(out_c), W'(exp_c));
      check({tag, "_out_v"}, W'(out_v), W'(exp_v));
      if (do_release) begin
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check({tag, "_released"}, W'(out_valid), W'(0));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_c      = 1'b0;
      #1;
      check("rst_sum0",      sum0,           W'(0));
      check("rst_out_c",     W'(out_c),      W'(0));
      check("rst_out_v",     W'(out_v),      W'(0));
      check("rst_out_valid", W'(out_valid),  W'(0));
      check("rst_in_ready",  W'(in_ready),   W'(1));
      check("rst_busy",      W'(busy),       W'(0));
      step();
      step();
      rst_n = 1'b1;
      step();

      // All-ones plus carry-in wraps to zero with an unsigned carry.
      run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
             64'h0, 1'b1, 1'b0, 1'b1);

      // Largest positive plus one: signed overflow, no carry; kept in DONE.
      run_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

      // Back-pressure: new operands offered while the result is held.
      in_valid = 1'b1;
      in_a     = 64'h1234_1234_1234_1234;
      in_b     = 64'h4321_4321_4321_4321;
      in_c     = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_out_valid", W'(out_valid), W'(1));
         check("hold_in_ready",  W'(in_ready),  W'(0));
         check("hold_sum0",      sum0,          64'h8000_0000_0000_0000);
         check("hold_out_v",     W'(out_v),     W'(1));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("rel_in_ready", W'(in_ready), W'(1));
      check("rel_keep_sum", sum0,         64'h8000_0000_0000_0000);
      check("rel_keep_v",   W'(out_v),    W'(1));
      step();
      check("rel_idle_busy", W'(busy), W'(0));

      // Reset in the middle of ADD, after two words have been written.
      in_a     = 64'h1111_2222_3333_4444;
      in_b     = 64'h1;
      in_c     = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_sum0",      sum0,          W'(0));
      check("mid_rst_out_c",     W'(out_c),     W'(0));
      check("mid_rst_out_v",     W'(out_v),     W'(0));
      check("mid_rst_out_valid", W'(out_valid), W'(0));
      check("mid_rst_busy",      W'(busy),      W'(0));
      check("mid_rst_in_ready",  W'(in_ready),  W'(1));
      step();
      rst_n = 1'b1;
      run_op("post_rst", 64'h0001_0000_0000_FFFF, 64'h1, 1'b0,
             64'h0001_0000_0001_0000, 1'b0, 1'b0, 1'b1);

      // Back-to-back with in_valid and out_ready both held high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = 64'h8000_0000_0000_0000;
      in_b      = 64'h8000_0000_0000_0000;
      in_c      = 1'b0;
      step();
      check("b2b_first_busy", W'(busy), W'(1));
      in_a = 64'h0123_4567_89AB_CDEF;
      in_b = 64'h1111_1111_1111_1111;
      in_c = 1'b1;
      wait_done("b2b_first", NW);
      check("b2b_first_sum0",  sum0,      64'h0);
      check("b2b_first_out_c", W'(out_c), W'(1));
      check("b2b_first_out_v", W'(out_v), W'(1));
      step();
      check("b2b_release_in_ready", W'(in_ready), W'(1));
      step();
      check("b2b_second_busy", W'(busy), W'(1));
      in_valid = 1'b0;
      wait_done("b2b_second", NW);
      check("b2b_second_sum0",  sum0,      64'h1234_5678_9ABC_DF01);
      check("b2b_second_out_c", W'(out_c), W'(0));
      check("b2b_second_out_v", W'(out_v), W'(0));
      step();
      out_ready = 1'b0;
      check("b2b_final_idle", W'(in_ready), W'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
